// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline-control unit:
// EX operand forwarding selects and writeback source selects.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC  = 2'd2
    } wb_sel_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard/pipeline control for the 5-stage core: shadow EX/MEM/WB
// state, stall/flush generation, EX forwarding and perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rf_wen,
    input  logic              id_is_load,
    input  logic              ex_jump,
    input  logic              mem_busy,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_en,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              ex_valid, mem_valid, wb_valid;
    logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
    logic              ex_wen, mem_wen, wb_wen;
    logic              ex_load, mem_load, wb_load;
    logic [REG_AW-1:0] ex_rs1, ex_rs2;
    logic              ex_use1, ex_use2;

    logic use1, use2;
    logic lu, raw;

    // x0 is hard-wired, so a write to it never creates a dependency
    function automatic logic writes(
        input logic              v,
        input logic              w,
        input logic [REG_AW-1:0] rd,
        input logic [REG_AW-1:0] r
    );
        return v && w && (rd == r) && (r != '0);
    endfunction

    assign use1 = id_valid && id_use_rs1;
    assign use2 = id_valid && id_use_rs2;

    assign lu = ex_load &&
        ((use1 && writes(ex_valid, ex_wen, ex_rd, id_rs1)) ||
         (use2 && writes(ex_valid, ex_wen, ex_rd, id_rs2)));

    // Regfile has no write-through, so WB still counts as a hazard
    assign raw = !FWD_EN && (
        (use1 && (writes(ex_valid,  ex_wen,  ex_rd,  id_rs1) ||
                  writes(mem_valid, mem_wen, mem_rd, id_rs1) ||
                  writes(wb_valid,  wb_wen,  wb_rd,  id_rs1))) ||
        (use2 && (writes(ex_valid,  ex_wen,  ex_rd,  id_rs2) ||
                  writes(mem_valid, mem_wen, mem_rd, id_rs2) ||
                  writes(wb_valid,  wb_wen,  wb_rd,  id_rs2))));

    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        ex_mem_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (mem_busy) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            ex_mem_en = 1'b0;
        end else if (ex_jump) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (lu || raw) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (FWD_EN && ex_valid) begin
            if (ex_use1 && writes(mem_valid, mem_wen, mem_rd, ex_rs1))
                fwd_a = FWD_MEM;
            else if (ex_use1 && writes(wb_valid, wb_wen, wb_rd, ex_rs1))
                fwd_a = FWD_WB;
            if (ex_use2 && writes(mem_valid, mem_wen, mem_rd, ex_rs2))
                fwd_b = FWD_MEM;
            else if (ex_use2 && writes(wb_valid, wb_wen, wb_rd, ex_rs2))
                fwd_b = FWD_WB;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid  <= 1'b0;
            mem_valid <= 1'b0;
            wb_valid  <= 1'b0;
            ex_rd     <= '0;
            mem_rd    <= '0;
            wb_rd     <= '0;
            ex_wen    <= 1'b0;
            mem_wen   <= 1'b0;
            wb_wen    <= 1'b0;
            ex_load   <= 1'b0;
            mem_load  <= 1'b0;
            wb_load   <= 1'b0;
            ex_rs1    <= '0;
            ex_rs2    <= '0;
            ex_use1   <= 1'b0;
            ex_use2   <= 1'b0;
        end else if (!mem_busy) begin
            wb_valid  <= mem_valid;
            wb_rd     <= mem_rd;
            wb_wen    <= mem_wen;
            wb_load   <= mem_load;
            mem_valid <= ex_valid;
            mem_rd    <= ex_rd;
            mem_wen   <= ex_wen;
            mem_load  <= ex_load;
            ex_valid  <= id_valid && !id_ex_flush;
            ex_rd     <= id_rd;
            ex_wen    <= id_rf_wen;
            ex_load   <= id_is_load;
            ex_rs1    <= id_rs1;
            ex_rs2    <= id_rs2;
            ex_use1   <= id_use_rs1;
            ex_use2   <= id_use_rs2;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!pc_en),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ex_jump && !mem_busy),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench: u0 forwards (32-bit counters), u1 stalls on
// every RAW hazard with 2-bit counters to exercise saturation.
module tb_pipe_ctrl;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2;
    logic       id_rf_wen, id_is_load;
    logic       ex_jump, mem_busy;

    logic        o0_pc_en, o0_if_id_en, o0_if_id_flush;
    logic        o0_id_ex_flush, o0_ex_mem_en;
    logic [1:0]  o0_fwd_a, o0_fwd_b;
    logic [31:0] o0_stall_cnt, o0_flush_cnt;

    logic        o1_pc_en, o1_if_id_en, o1_if_id_flush;
    logic        o1_id_ex_flush, o1_ex_mem_en;
    logic [1:0]  o1_fwd_a, o1_fwd_b;
    logic [1:0]  o1_stall_cnt, o1_flush_cnt;

    int errs = 0;
    int checks = 0;

    pipe_ctrl #(.REG_AW(5), .FWD_EN(1'b1), .CNT_W(32)) u0 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_rf_wen(id_rf_wen),
        .id_is_load(id_is_load), .ex_jump(ex_jump),
        .mem_busy(mem_busy), .pc_en(o0_pc_en),
        .if_id_en(o0_if_id_en), .if_id_flush(o0_if_id_flush),
        .id_ex_flush(o0_id_ex_flush), .ex_mem_en(o0_ex_mem_en),
        .fwd_a(o0_fwd_a), .fwd_b(o0_fwd_b),
        .stall_cnt(o0_stall_cnt), .flush_cnt(o0_flush_cnt)
    );

    pipe_ctrl #(.REG_AW(5), .FWD_EN(1'b0), .CNT_W(2)) u1 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_rf_wen(id_rf_wen),
        .id_is_load(id_is_load), .ex_jump(ex_jump),
        .mem_busy(mem_busy), .pc_en(o1_pc_en),
        .if_id_en(o1_if_id_en), .if_id_flush(o1_if_id_flush),
        .id_ex_flush(o1_id_ex_flush), .ex_mem_en(o1_ex_mem_en),
        .fwd_a(o1_fwd_a), .fwd_b(o1_fwd_b),
        .stall_cnt(o1_stall_cnt), .flush_cnt(o1_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic id_set(input logic v, input logic [4:0] r1,
                          input logic [4:0] r2, input logic u1b,
                          input logic u2b, input logic [4:0] rd,
                          input logic w, input logic ld);
        id_valid   = v;
        id_rs1     = r1;
        id_rs2     = r2;
        id_use_rs1 = u1b;
        id_use_rs2 = u2b;
        id_rd      = rd;
        id_rf_wen  = w;
        id_is_load = ld;
        #1;
    endtask

    task automatic id_idle();
        id_set(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        id_idle();
        repeat (3) tick();
    endtask

    initial begin
        reset    = 1'b0;
        ex_jump  = 1'b0;
        mem_busy = 1'b0;
        id_idle();
        #12;
        chk("rst_pc_en", 32'(o0_pc_en), 32'd1);
        chk("rst_if_id_en", 32'(o0_if_id_en), 32'd1);
        chk("rst_ex_mem_en", 32'(o0_ex_mem_en), 32'd1);
        tick();
        reset = 1'b1;
        #1;
        chk("post_pc_en", 32'(o0_pc_en), 32'd1);
        chk("post_flushes", 32'({o0_if_id_flush, o0_id_ex_flush}), 32'd0);
        chk("post_fwd", 32'({o0_fwd_a, o0_fwd_b}), 32'd0);
        chk("post_stall_cnt", o0_stall_cnt, 32'd0);
        chk("post_flush_cnt", o0_flush_cnt, 32'd0);
        chk("post_u1_stall", 32'(o1_stall_cnt), 32'd0);

        // add x5,x1,x2 ; sub x6,x5,x1 -> forward from MEM
        id_set(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        id_set(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        chk("mem_fwd_no_stall", 32'(o0_pc_en), 32'd1);
        tick();
        chk("fwd_a_mem", 32'(o0_fwd_a), 32'd1);
        chk("fwd_b_mem_case", 32'(o0_fwd_b), 32'd0);
        drain();

        // add x5 ; or x9,x10,x11 ; sub x6,x5,x1 -> forward from WB
        id_set(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        id_set(1'b1, 5'd10, 5'd11, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        tick();
        id_set(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        chk("wb_fwd_no_stall", 32'(o0_pc_en), 32'd1);
        tick();
        chk("fwd_a_wb", 32'(o0_fwd_a), 32'd2);
        drain();

        // lw x7 ; add x10,x3,x7 -> one load-use bubble
        id_set(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        id_set(1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
        chk("lu_pc_en", 32'(o0_pc_en), 32'd0);
        chk("lu_if_id_en", 32'(o0_if_id_en), 32'd0);
        chk("lu_id_ex_flush", 32'(o0_id_ex_flush), 32'd1);
        chk("lu_ex_mem_en", 32'(o0_ex_mem_en), 32'd1);
        tick();
        chk("lu_resume", 32'(o0_pc_en), 32'd1);
        tick();
        chk("lu_fwd_b", 32'(o0_fwd_b), 32'd2);
        chk("lu_fwd_a", 32'(o0_fwd_a), 32'd0);
        chk("lu_stall_cnt", o0_stall_cnt, 32'd1);
        drain();

        // jump beats load-use
        id_set(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        ex_jump = 1'b1;
        id_set(1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
        chk("jmp_pc_en", 32'(o0_pc_en), 32'd1);
        chk("jmp_if_id_flush", 32'(o0_if_id_flush), 32'd1);
        chk("jmp_id_ex_flush", 32'(o0_id_ex_flush), 32'd1);
        tick();
        ex_jump = 1'b0;
        id_idle();
        chk("jmp_flush_cnt", o0_flush_cnt, 32'd1);
        chk("jmp_stall_cnt", o0_stall_cnt, 32'd1);
        drain();

        // mem_busy for 3 cycles while a MEM forward is live
        id_set(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        id_set(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        tick();
        id_idle();
        mem_busy = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("busy_pc_en", 32'(o0_pc_en), 32'd0);
            chk("busy_if_id_en", 32'(o0_if_id_en), 32'd0);
            chk("busy_ex_mem_en", 32'(o0_ex_mem_en), 32'd0);
            chk("busy_flush", 32'(o0_id_ex_flush), 32'd0);
            chk("busy_fwd_a", 32'(o0_fwd_a), 32'd1);
            tick();
        end
        mem_busy = 1'b0;
        #1;
        chk("busy_after_fwd_a", 32'(o0_fwd_a), 32'd1);
        chk("busy_stall_cnt", o0_stall_cnt, 32'd4);
        chk("busy_release_pc", 32'(o0_pc_en), 32'd1);
        drain();

        // x0 writer then x0 reader
        id_set(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
        tick();
        id_set(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        chk("x0_no_stall", 32'(o0_pc_en), 32'd1);
        tick();
        chk("x0_fwd", 32'({o0_fwd_a, o0_fwd_b}), 32'd0);
        drain();

        // FWD_EN=0 instance: fresh start
        reset = 1'b0;
        #1;
        chk("u1_rst_stall", 32'(o1_stall_cnt), 32'd0);
        tick();
        reset = 1'b1;
        id_set(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        chk("u1_first_free", 32'(o1_pc_en), 32'd1);
        tick();
        id_set(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        chk("u1_raw_ex", 32'(o1_pc_en), 32'd0);
        chk("u1_raw_flush", 32'(o1_id_ex_flush), 32'd1);
        tick();
        chk("u1_raw_mem", 32'(o1_pc_en), 32'd0);
        tick();
        chk("u1_raw_wb", 32'(o1_pc_en), 32'd0);
        tick();
        chk("u1_raw_done", 32'(o1_pc_en), 32'd1);
        chk("u1_stall_3", 32'(o1_stall_cnt), 32'd3);
        tick();
        id_set(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);
        chk("u1_fwd_off", 32'({o1_fwd_a, o1_fwd_b}), 32'd0);
        chk("u1_raw4", 32'(o1_pc_en), 32'd0);
        tick();
        chk("u1_stall_sat", 32'(o1_stall_cnt), 32'd3);

        // reset in the middle of a stall
        reset = 1'b0;
        #1;
        chk("mid_rst_pc_en", 32'(o1_pc_en), 32'd1);
        chk("mid_rst_flush", 32'(o1_id_ex_flush), 32'd0);
        chk("mid_rst_stall", 32'(o1_stall_cnt), 32'd0);
        tick();
        reset = 1'b1;
        #1;
        chk("rel_free", 32'(o1_pc_en), 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
